// File: rtl/video_timing_if.sv
// Raster stream bundle from the timing generator to pixel-stream consumers.
interface video_timing_if #(
  parameter int CNT_W = 12
);
  logic             o_vsync;
  logic             o_hsync;
  logic             o_de;
  logic             o_sof;
  logic [CNT_W-1:0] o_x;
  logic [CNT_W-1:0] o_y;
  logic [15:0]      o_frame_cnt;
  logic             o_busy;

  modport master (
    output o_vsync, o_hsync, o_de, o_sof, o_x, o_y, o_frame_cnt, o_busy
  );
  modport slave (
    input  o_vsync, o_hsync, o_de, o_sof, o_x, o_y, o_frame_cnt, o_busy
  );
endinterface

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: sync/de/coordinates are registered
// decodes of the (h,v) position; runs only stop on a frame boundary.
module video_timing_gen #(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 8,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter int CNT_W    = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  video_timing_if.master vid
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_geometry
      $fatal(1, "video_timing_gen: illegal geometry parameters");
    end
  endgenerate

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_A0   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_A1   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_A0   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_A1   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             vsync_q, vsync_d, hsync_q, hsync_d, de_q, de_d;
  logic             sof_q, sof_d, busy_q, busy_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             run, h_end, v_end, h_act, v_act;

  assign run   = (state_q == RUN);
  assign h_end = (h_cnt_q == H_LAST);
  assign v_end = (v_cnt_q == V_LAST);
  assign h_act = (h_cnt_q >= H_A0) && (h_cnt_q < H_A1);
  assign v_act = (v_cnt_q >= V_A0) && (v_cnt_q < V_A1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // i_en only matters in IDLE and on the last clock of a frame.
  always_comb begin
    state_d     = state_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (i_en) state_d = RUN;
      end
      RUN: begin
        h_cnt_d = h_end ? '0 : h_cnt_q + CNT_W'(1);
        if (h_end) v_cnt_d = v_end ? '0 : v_cnt_q + CNT_W'(1);
        if (h_end && v_end) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (!i_en) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hsync_d = !(run && (h_cnt_q < H_SE));
    vsync_d = !(run && (v_cnt_q < V_SE));
    de_d    = run && h_act && v_act;
    sof_d   = run && (h_cnt_q == '0) && (v_cnt_q == '0);
    busy_d  = run;
    x_d     = de_d ? h_cnt_q - H_A0 : '0;
    y_d     = de_d ? v_cnt_q - V_A0 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
      vsync_q     <= 1'b1;
      hsync_q     <= 1'b1;
      de_q        <= 1'b0;
      sof_q       <= 1'b0;
      busy_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_d;
      hsync_q     <= hsync_d;
      de_q        <= de_d;
      sof_q       <= sof_d;
      busy_q      <= busy_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign vid.o_vsync     = vsync_q;
  assign vid.o_hsync     = hsync_q;
  assign vid.o_de        = de_q;
  assign vid.o_sof       = sof_q;
  assign vid.o_x         = x_q;
  assign vid.o_y         = y_q;
  assign vid.o_frame_cnt = frame_cnt_q;
  assign vid.o_busy      = busy_q;
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Synthesizable raster timing generator producing the `i_vsync`/`i_hsync`/`i_de` stream consumed by the PPM file read model and other pixel-stream stages. It runs free-running frames while enabled, stops cleanly on frame boundaries, and exposes active-area pixel coordinates, a start-of-frame pulse and a frame counter for checkers and stimulus models. Horizontal and vertical geometry is fully parameterized. Defaults match the 320x240 test image.

## Interface
- H_ACTIVE, 320, active pixels per line
- H_FP, 8, horizontal front porch (clocks)
- H_SYNC, 4, hsync pulse width (clocks)
- H_BP, 8, horizontal back porch (clocks)
- V_ACTIVE, 240, active lines per frame
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 2, vertical back porch (lines)
- CNT_W, 12, width of position counters and coordinate outputs
- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_en  in  1  run request, level-sensitive
- o_vsync  out  1  vertical sync, active low
- o_hsync  out  1  horizontal sync, active low
- o_de  out  1  data enable, high on active pixels
- o_sof  out  1  one-clock pulse on first clock of each frame
- o_x  out  CNT_W  active column 0..H_ACTIVE-1 while o_de=1, else 0
- o_y  out  CNT_W  active line 0..V_ACTIVE-1 while o_de=1, else 0
- o_frame_cnt  out  16  completed-frame count, wraps 0xFFFF->0
- o_busy  out  1  high while in RUN

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 340). V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (default 246). All parameters must be >= 1, and H_TOTAL and V_TOTAL must be < 2^CNT_W. Elaboration-time assertion fails otherwise.
- Line order by h_cnt: SYNC [0,H_SYNC), BP, ACTIVE [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), FP. Frame order by v_cnt uses the same scheme in lines.
- hsync is low when h_cnt < H_SYNC, on every line including vertical blanking.
- vsync is low for whole lines with v_cnt < V_SYNC, aligned to h_cnt=0.
- de = h in ACTIVE AND v in ACTIVE. o_x = h_cnt-(H_SYNC+H_BP) and o_y = v_cnt-(V_SYNC+V_BP) when de=1, else 0.
- FSM states:
  - IDLE: counters are held at 0 and outputs at idle values. IDLE->RUN when i_en=1 is sampled.
  - RUN: h_cnt increments every clock and wraps at H_TOTAL-1, at which point v_cnt increments. v_cnt wraps at V_TOTAL-1.
- At the last clock of a frame (h=H_TOTAL-1, v=V_TOTAL-1):
  - o_frame_cnt increments.
  - If i_en=1, RUN continues back-to-back at (0,0).
  - If i_en=0, the FSM goes to IDLE.
  - i_en is ignored at all other positions in RUN, so deassertion mid-frame always completes the frame.

## Timing
- Reset values: o_vsync=1, o_hsync=1, o_de=0, o_sof=0, o_x=0, o_y=0, o_frame_cnt=0, o_busy=0, FSM=IDLE, h_cnt=v_cnt=0.
- All outputs are registered decodes of the counter position, one clock after the counter holds that position.
- Start-up: i_en=1 sampled at edge E0 gives RUN with counters at (0,0) at E0. At E1 the outputs are o_sof=1, o_vsync=0, o_hsync=0, o_busy=1.
- Stop: the frame-end edge moves the FSM to IDLE and counters to (0,0). The next edge drives idle output values: vsync=1, hsync=1, de=0, busy=0.
- Restart: the earliest restart is i_en=1 sampled on the first edge in IDLE.
- Reset asserted mid-frame forces reset values immediately (asynchronously). Frame count is lost.
- Downstream PPM read model adds 2 clocks, and its file-open edge is the o_vsync falling edge.

## Test plan
- Reset with i_en=0 for 20 clocks -> all outputs at reset values, o_vsync stays 1, no o_sof.
- Default params, i_en=1 held -> first o_sof one clock after enable; hsync low exactly 4 clocks every 340; vsync low exactly 680 clocks; 320 de clocks per active line; 76800 de clocks per frame; o_sof period 83640 clocks.
- Coordinate check -> first de of frame has o_x=0, o_y=0; last has o_x=319, o_y=239; o_x/o_y are 0 whenever de=0.
- Drop i_en at pixel (100, line 50) -> frame completes with all 76800 de; o_frame_cnt=1; idle outputs thereafter; no second o_sof.
- Drop then reassert i_en within a frame -> next frame follows back-to-back with no gap and o_frame_cnt increments each frame. Assert rst_n low mid-frame -> outputs reset immediately, and restart behaves as first start-up.
- Small geometry (H 2/1/4/1, V 1/1/3/1) with PPM model downstream -> H_TOTAL=8, V_TOTAL=6; exactly 12 de per frame, consumed as 12 pixels read from file.
